csa_seq_multiplier: RTL

//  Sequential unsigned WIDTH x WIDTH multiplier for the Wallace-tree datapath.

---
 rtl/csa_seq_multiplier.sv | 107 ++++++++++
 1 files changed

// File: rtl/csa_seq_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: PP_PER_CYCLE carry-save rows per clock, then one CPA.
// Optional macro CSA_EARLY_TERM_EN: leave ACCUM once the remaining multiplier bits are all zero.
module csa_seq_multiplier #(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int N  = WIDTH / PP_PER_CYCLE;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE, S_DONE} state_t;

    state_t            state_q;
    logic [PW-1:0]     sum_q, carry_q, sum_d, carry_d;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     product_q;
    logic              out_valid_q;
    logic              accum_last;
    logic [PW-1:0]     pp_row, carry_row;

    // Multiplicand moves left and multiplier right each cycle, so row k always uses mplier_q[k].
    always_comb begin
        sum_d     = sum_q;
        carry_d   = carry_q;
        pp_row    = '0;
        carry_row = '0;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            pp_row    = (mcand_q << k) & {PW{mplier_q[k]}};
            carry_row = ((sum_d & carry_d) | (sum_d & pp_row) | (carry_d & pp_row)) << 1;
            sum_d     = sum_d ^ carry_d ^ pp_row;
            carry_d   = carry_row;
        end
    end

`ifdef CSA_EARLY_TERM_EN
    assign accum_last = (cnt_q == CW'(N - 1)) || ((mplier_q >> PP_PER_CYCLE) == '0);
`else
    assign accum_last = (cnt_q == CW'(N - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= PW'(a);
                        mplier_q <= b;
                        sum_q    <= '0;
                        carry_q  <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    sum_q    <= sum_d;
                    carry_q  <= carry_d;
                    mcand_q  <= mcand_q << PP_PER_CYCLE;
                    mplier_q <= mplier_q >> PP_PER_CYCLE;
                    cnt_q    <= cnt_q + 1'b1;
                    if (accum_last) begin
                        state_q <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    product_q   <= sum_q + carry_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign busy      = (state_q == S_ACCUM) || (state_q == S_RESOLVE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
